// File: rtl/systolic_array_scheduler.sv
// -----------------------------------------------------------------------------
// systolic_array_scheduler
//
// Purpose:
//   Sequences one output-stationary matrix-multiply tile on a SIZE x SIZE
//   PE array. The flow is:
//     - clear the PE accumulators;
//     - issue skewed A-row and B-column operand streams;
//     - wait PE_LAT cycles for the array to settle;
//     - drain the SIZE*SIZE results in row-major order over valid/ready.
//   The PE array has no control logic of its own. Every array timing
//   decision is made here.
//
// Parameters:
//   SIZE    array dimension (rows = cols), must be >= 2
//   K_MAX   maximum inner dimension per tile
//   KW      width of k_len
//   KIW     width of one operand k index
//   PE_LAT  cycles from the last operand entering PE[SIZE-1][SIZE-1] until
//           its sum is valid
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   start, k_len       tile request; sampled only in IDLE
//   busy               high in every state except IDLE (registered)
//   done               one-cycle pulse after the last result handshake
//   cmd_err            one-cycle pulse, the cycle after an illegal start
//   acc_clear          one-cycle pulse clearing all PE accumulators
//   a_row_valid/a_row_k   per-row operand valid and k index (slice r)
//   b_col_valid/b_col_k   per-column operand valid and k index (slice c)
//   res_valid/res_ready   result handshake
//   res_row/res_col       coordinates of the offered result
//   res_last              high with the final element (SIZE-1, SIZE-1)
//   perf_stall_cycles     count of drain cycles stalled by the consumer
//
// Optional feature:
//   Define SYSTOLIC_SCHED_PERF_CNT_EN to build the saturating drain-stall
//   counter. Without it, perf_stall_cycles is tied to zero.
// -----------------------------------------------------------------------------
module systolic_array_scheduler #(
   parameter int SIZE   = 4,
   parameter int K_MAX  = 16,
   parameter int KW     = $clog2(K_MAX + 1),
   parameter int KIW    = $clog2(K_MAX),
   parameter int PE_LAT = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   output logic                    busy,
   output logic                    done,
   output logic                    cmd_err,
   output logic                    acc_clear,
   output logic [SIZE-1:0]         a_row_valid,
   output logic [SIZE*KIW-1:0]     a_row_k,
   output logic [SIZE-1:0]         b_col_valid,
   output logic [SIZE*KIW-1:0]     b_col_k,
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [$clog2(SIZE)-1:0] res_row,
   output logic [$clog2(SIZE)-1:0] res_col,
   output logic                    res_last,
   output logic [15:0]             perf_stall_cycles
);

   localparam int RW  = $clog2(SIZE);
   localparam int NEL = SIZE * SIZE;
   localparam int EW  = $clog2(NEL);
   // The step counter must reach k_reg + 2*SIZE - 3.
   // It must also hold r + k_reg for every row, for the window compare.
   localparam int TW  = $clog2(K_MAX + 2 * SIZE);
   localparam int SW  = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CLEAR  = 3'd1;
   localparam logic [2:0] S_FEED   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_DRAIN  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   logic [2:0]    state_q, state_d;
   logic [KW-1:0] k_reg_q, k_reg_d;
   logic [TW-1:0] t_q, t_d;
   logic [SW-1:0] lat_q, lat_d;
   logic [EW-1:0] e_q, e_d;
   logic          busy_q;
   logic          cmd_err_q, cmd_err_d;

   logic          k_legal;
   logic          feed_last;
   logic          drain_last;

   assign k_legal    = (k_len != '0) && (k_len <= KW'(K_MAX));
   assign feed_last  = (t_q == (TW'(k_reg_q) + TW'(2 * SIZE - 3)));
   assign drain_last = (e_q == EW'(NEL - 1));

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d   = state_q;
      k_reg_d   = k_reg_q;
      t_d       = t_q;
      lat_d     = lat_q;
      e_d       = e_q;
      cmd_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (k_legal) begin
                  k_reg_d = k_len;
                  state_d = S_CLEAR;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            t_d     = '0;
            state_d = S_FEED;
         end
         S_FEED: begin
            if (feed_last) begin
               lat_d = '0;
               e_d   = '0;
               // With zero PE latency the last sum is already valid.
               state_d = (PE_LAT == 0) ? S_DRAIN : S_SETTLE;
            end else begin
               t_d = t_q + TW'(1);
            end
         end
         S_SETTLE: begin
            if (lat_q == SW'(PE_LAT - 1)) begin
               e_d     = '0;
               state_d = S_DRAIN;
            end else begin
               lat_d = lat_q + SW'(1);
            end
         end
         S_DRAIN: begin
            if (res_ready) begin
               if (drain_last) begin
                  state_d = S_DONE;
               end else begin
                  e_d = e_q + EW'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         k_reg_q   <= '0;
         t_q       <= '0;
         lat_q     <= '0;
         e_q       <= '0;
         busy_q    <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_reg_q   <= k_reg_d;
         t_q       <= t_d;
         lat_q     <= lat_d;
         e_q       <= e_d;
         // Registered from the next state, so it always tracks state_q.
         busy_q    <= (state_d != S_IDLE);
         cmd_err_q <= cmd_err_d;
      end
   end

   // ---------------------------------------------------------------- operand skew
   // Row r (and column r) is live for k_reg cycles starting at step t = r.
   // During that window it carries k = t - r.
   // PE(r,c) therefore sees matching indices at t = k + r + c.
   // Rows and columns follow the same rule, so one vector drives both buses.
   logic [SIZE-1:0]     op_valid;
   logic [SIZE*KIW-1:0] op_k;
   logic [TW-1:0]       op_diff;

   always_comb begin
      op_valid = '0;
      op_k     = '0;
      op_diff  = '0;
      for (int r = 0; r < SIZE; r++) begin
         if ((state_q == S_FEED) && (t_q >= TW'(r)) &&
             (t_q < (TW'(r) + TW'(k_reg_q)))) begin
            op_valid[r]           = 1'b1;
            op_diff               = t_q - TW'(r);
            op_k[r*KIW +: KIW]    = op_diff[KIW-1:0];
         end
      end
   end

   assign a_row_valid = op_valid;
   assign a_row_k     = op_k;
   assign b_col_valid = op_valid;
   assign b_col_k     = op_k;

   // ---------------------------------------------------------------- result drain
   logic [EW-1:0] row_full;
   logic [EW-1:0] col_full;

   assign row_full  = e_q / EW'(SIZE);
   assign col_full  = e_q % EW'(SIZE);

   assign res_valid = (state_q == S_DRAIN);
   // Coordinates are zero outside DRAIN.
   // Otherwise the final e would linger on the bus while idle.
   assign res_row   = res_valid ? row_full[RW-1:0] : '0;
   assign res_col   = res_valid ? col_full[RW-1:0] : '0;
   assign res_last  = res_valid && drain_last;

   assign busy      = busy_q;
   assign done      = (state_q == S_DONE);
   assign acc_clear = (state_q == S_CLEAR);
   assign cmd_err   = cmd_err_q;

   // ---------------------------------------------------------------- stall counter
`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_q <= '0;
      end else if (state_q == S_CLEAR) begin
         perf_q <= '0;
      end else if ((state_q == S_DRAIN) && !res_ready && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign perf_stall_cycles = perf_q;
`else
   assign perf_stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_systolic_array_scheduler.sv
module tb_systolic_array_scheduler;

   localparam int SIZE   = 4;
   localparam int K_MAX  = 16;
   localparam int KW     = 5;
   localparam int KIW    = 4;
   localparam int PE_LAT = 1;
   localparam int NEL    = SIZE * SIZE;

`ifdef SYSTOLIC_SCHED_PERF_CNT_EN
   localparam int PERF_ON = 1;
`else
   localparam int PERF_ON = 0;
`endif

   logic                clk;
   logic                rst;
   logic                start;
   logic [KW-1:0]       k_len;
   logic                busy;
   logic                done;
   logic                cmd_err;
   logic                acc_clear;
   logic [SIZE-1:0]     a_row_valid;
   logic [SIZE*KIW-1:0] a_row_k;
   logic [SIZE-1:0]     b_col_valid;
   logic [SIZE*KIW-1:0] b_col_k;
   logic                res_valid;
   logic                res_ready;
   logic [1:0]          res_row;
   logic [1:0]          res_col;
   logic                res_last;
   logic [15:0]         perf_stall_cycles;

   systolic_array_scheduler #(
      .SIZE(SIZE), .K_MAX(K_MAX), .KW(KW), .KIW(KIW), .PE_LAT(PE_LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .k_len(k_len),
      .busy(busy), .done(done), .cmd_err(cmd_err), .acc_clear(acc_clear),
      .a_row_valid(a_row_valid), .a_row_k(a_row_k),
      .b_col_valid(b_col_valid), .b_col_k(b_col_k),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_row(res_row), .res_col(res_col), .res_last(res_last),
      .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int col;
      int last;
   } exp_t;

   exp_t sb[$];
   int   tests;
   int   fails;

   // Expected latency from CLEAR entry to the done pulse, both cycles inclusive
   function automatic int tile_latency(input int k, input int stalls);
      return 1 + (k + 2 * SIZE - 2) + PE_LAT + NEL + 1 + stalls;
   endfunction

   // Drives one tile and scoreboards every observable along the way.
   // abort_at >= 0 asserts rst when the element with that index is offered.
   task automatic run_tile(input int k, input bit toggle_ready, input bit glitch,
                           input int abort_at, input int exp_perf, input int exp_lat);
      int clear_cyc;
      int done_cyc;
      int fidx;
      int popped;
      int drain_idx;
      bit prev_stall;
      bit got_done;
      bit aborted;
      logic [1:0] prev_row;
      logic [1:0] prev_col;
      logic       prev_last;
      logic [1:0] er;
      logic [1:0] ec;
      logic       el;
      logic [SIZE-1:0]     ev;
      logic [SIZE*KIW-1:0] ek;
      exp_t ex;
      clear_cyc  = -1;
      done_cyc   = -1;
      popped     = 0;
      drain_idx  = 0;
      prev_stall = 0;
      got_done   = 0;
      aborted    = 0;
      prev_row   = '0;
      prev_col   = '0;
      prev_last  = 1'b0;
      @(negedge clk);
      start     = 1'b1;
      k_len     = KW'(k);
      res_ready = 1'b1;
      for (int i = 0; i < NEL; i++) sb.push_back('{i / SIZE, i % SIZE, (i == NEL - 1) ? 1 : 0});
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         k_len = '0;
         if (acc_clear && clear_cyc < 0) clear_cyc = cyc;
         fidx = (clear_cyc >= 0) ? (cyc - clear_cyc - 1) : -1;
         ev = '0;
         ek = '0;
         if (fidx >= 0 && fidx < k + 2 * SIZE - 2) begin
            for (int r = 0; r < SIZE; r++) begin
               if (fidx >= r && fidx < r + k) begin
                  ev[r] = 1'b1;
                  ek[r*KIW +: KIW] = KIW'(fidx - r);
               end
            end
         end
         tests++;
         if (a_row_valid !== ev || b_col_valid !== ev || a_row_k !== ek || b_col_k !== ek) begin
            fails++;
            $display("FAIL operands cyc=%0d: got av=%b bv=%b ak=%h bk=%h, expected v=%b k=%h",
                     cyc, a_row_valid, b_col_valid, a_row_k, b_col_k, ev, ek);
         end
         tests++;
         if (cmd_err !== 1'b0) begin
            fails++;
            $display("FAIL cmd_err_in_tile cyc=%0d: got %b expected 0", cyc, cmd_err);
         end
         if (clear_cyc >= 0) begin
            tests++;
            if (busy !== 1'b1) begin
               fails++;
               $display("FAIL busy_in_tile cyc=%0d: got %b expected 1", cyc, busy);
            end
         end
         if (glitch && (fidx == 2 || (res_valid && drain_idx == 3))) begin
            start = 1'b1;
            k_len = '0;
         end
         if (done) begin
            got_done = 1;
            done_cyc = cyc;
            break;
         end
         if (res_valid) begin
            if (prev_stall) begin
               tests++;
               if (res_row !== prev_row || res_col !== prev_col || res_last !== prev_last) begin
                  fails++;
                  $display("FAIL hold_stable: got (%0d,%0d,%b) expected (%0d,%0d,%b)",
                           res_row, res_col, res_last, prev_row, prev_col, prev_last);
               end
            end
            if (abort_at >= 0 && popped == abort_at) begin
               rst     = 1'b1;
               aborted = 1;
               break;
            end
            res_ready = toggle_ready ? (drain_idx % 2 == 0) : 1'b1;
            drain_idx++;
            if (res_ready) begin
               tests++;
               if (sb.size() == 0) begin
                  fails++;
                  $display("FAIL sb_underflow: got extra element (%0d,%0d) expected none",
                           res_row, res_col);
               end else begin
                  ex = sb.pop_front();
                  er = 2'(ex.row);
                  ec = 2'(ex.col);
                  el = (ex.last != 0);
                  if (res_row !== er || res_col !== ec || res_last !== el) begin
                     fails++;
                     $display("FAIL result #%0d: got (%0d,%0d,last=%b) expected (%0d,%0d,last=%b)",
                              popped, res_row, res_col, res_last, er, ec, el);
                  end
               end
               popped++;
               prev_stall = 0;
            end else begin
               prev_stall = 1;
               prev_row   = res_row;
               prev_col   = res_col;
               prev_last  = res_last;
            end
         end else begin
            res_ready = 1'b1;
         end
      end
      if (!got_done && !aborted) begin
         tests++;
         fails++;
         $display("FAIL tile_timeout k=%0d: got no done expected done within 400 cycles", k);
      end
      if (got_done) begin
         tests++;
         if (done_cyc - clear_cyc + 1 != exp_lat) begin
            fails++;
            $display("FAIL latency k=%0d: got %0d expected %0d", k, done_cyc - clear_cyc + 1, exp_lat);
         end
         tests++;
         if (sb.size() != 0 || popped != NEL) begin
            fails++;
            $display("FAIL result_count: got %0d accepted (%0d left) expected %0d", popped, sb.size(), NEL);
         end
         @(negedge clk);
         tests++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL after_done: got done=%b busy=%b expected 0 0", done, busy);
         end
         tests++;
         if (perf_stall_cycles !== 16'(exp_perf)) begin
            fails++;
            $display("FAIL perf_stall: got %0d expected %0d", perf_stall_cycles, exp_perf);
         end
      end
      res_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0 || acc_clear !== 1'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got busy=%b done=%b err=%b clr=%b expected all 0",
                  busy, done, cmd_err, acc_clear);
      end
      tests++;
      if (a_row_valid !== '0 || b_col_valid !== '0 || a_row_k !== '0 || b_col_k !== '0) begin
         fails++;
         $display("FAIL reset_operands: got %b %b %h %h expected 0", a_row_valid, b_col_valid, a_row_k, b_col_k);
      end
      tests++;
      if (res_valid !== 1'b0 || res_row !== '0 || res_col !== '0 || res_last !== 1'b0 ||
          perf_stall_cycles !== 16'd0) begin
         fails++;
         $display("FAIL reset_result: got v=%b r=%0d c=%0d l=%b perf=%0d expected all 0",
                  res_valid, res_row, res_col, res_last, perf_stall_cycles);
      end
   endtask

   task automatic test_basic();
      run_tile(4, 1'b0, 1'b0, -1, 0, tile_latency(4, 0));
   endtask

   task automatic test_cmd_err();
      int bad[2];
      bad[0] = 0;
      bad[1] = 17;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         start = 1'b1;
         k_len = KW'(bad[i]);
         @(negedge clk);
         start = 1'b0;
         k_len = '0;
         tests++;
         if (cmd_err !== 1'b1 || busy !== 1'b0 || acc_clear !== 1'b0) begin
            fails++;
            $display("FAIL cmd_err_pulse k=%0d: got err=%b busy=%b clr=%b expected 1 0 0",
                     bad[i], cmd_err, busy, acc_clear);
         end
         @(negedge clk);
         tests++;
         if (cmd_err !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL cmd_err_single k=%0d: got err=%b busy=%b expected 0 0", bad[i], cmd_err, busy);
         end
      end
   endtask

   task automatic test_backpressure();
      run_tile(1, 1'b1, 1'b0, -1, (PERF_ON != 0) ? 15 : 0, tile_latency(1, 15));
      repeat (3) @(negedge clk);
      tests++;
      if (perf_stall_cycles !== 16'((PERF_ON != 0) ? 15 : 0)) begin
         fails++;
         $display("FAIL perf_hold: got %0d expected %0d", perf_stall_cycles, (PERF_ON != 0) ? 15 : 0);
      end
   endtask

   task automatic test_start_ignored();
      run_tile(3, 1'b0, 1'b1, -1, 0, tile_latency(3, 0));
   endtask

   task automatic test_reset_mid_drain();
      int done_seen;
      done_seen = 0;
      run_tile(3, 1'b0, 1'b0, 7, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      tests++;
      if (res_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         fails++;
         $display("FAIL abort_idle: got v=%b busy=%b done=%b expected 0 0 0", res_valid, busy, done);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (done === 1'b1 || res_valid === 1'b1) done_seen++;
      end
      tests++;
      if (done_seen != 0) begin
         fails++;
         $display("FAIL abort_no_done: got %0d active cycles expected 0", done_seen);
      end
      sb.delete();
      run_tile(2, 1'b0, 1'b0, -1, 0, tile_latency(2, 0));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before 2 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tests     = 0;
      fails     = 0;
      clk       = 1'b0;
      rst       = 1'b1;
      start     = 1'b0;
      k_len     = '0;
      res_ready = 1'b1;
      test_reset();
      test_basic();
      test_cmd_err();
      test_backpressure();
      test_start_ignored();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/systolic_array_scheduler.md
Name: systolic_array_scheduler

Overview:
- Sequences one output-stationary matrix-multiply tile on the SIZE x SIZE PE array: clears the accumulators, issues skewed A-row and B-column operand streams, waits for the array to settle, then drains the SIZE*SIZE results over a valid/ready handshake.
- Sits between the tile command source (start/k_len) and the PE array and operand buffers.
- Owns all array timing; the array itself has no control logic.

Parameters:
- SIZE, 4: array dimension (rows = cols).
- K_MAX, 16: maximum inner dimension per tile.
- KW, $clog2(K_MAX+1): width of k_len.
- KIW, $clog2(K_MAX): width of one operand k index.
- PE_LAT, 1: cycles from the last operand entering PE[SIZE-1][SIZE-1] until its sum is valid.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle tile request; sampled only in IDLE.
- k_len  in  KW  inner dimension, legal 1..K_MAX; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result handshake.
- cmd_err  out  1  one-cycle pulse on an illegal start.
- acc_clear  out  1  one-cycle pulse clearing all PE accumulators.
- a_row_valid  out  SIZE  bit r: row r's A operand is valid this cycle.
- a_row_k  out  SIZE*KIW  k index for row r, in slice r; 0 when the row is invalid.
- b_col_valid  out  SIZE  bit c: column c's B operand is valid this cycle.
- b_col_k  out  SIZE*KIW  k index for column c, in slice c; 0 when the column is invalid.
- res_valid  out  1  result element offered.
- res_ready  in  1  consumer accepts the element.
- res_row  out  $clog2(SIZE)  row of the offered element.
- res_col  out  $clog2(SIZE)  column of the offered element.
- res_last  out  1  high with the final element (SIZE-1, SIZE-1).
- perf_stall_cycles  out  16  drain stall counter (see Optional Feature).

Behaviour:
- Reset: state IDLE; every output 0; all counters 0.
- Reset asserted in any state returns to IDLE on the next edge. No done pulse and no partial drain.
- States: IDLE -> CLEAR -> FEED -> SETTLE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start with 1 <= k_len <= K_MAX latches k_len into k_reg and moves to CLEAR.
  - start with k_len==0 or k_len>K_MAX pulses cmd_err in the next cycle and stays in IDLE.
- CLEAR: acc_clear=1 for exactly one cycle; step counter t := 0; next state FEED.
- FEED: lasts k_reg + 2*SIZE - 2 cycles, t = 0 .. k_reg+2*SIZE-3.
  - Row r: a_row_valid[r]=1 iff r <= t < r+k_reg; a_row_k[r] = t-r.
  - Column c: the same rule with c in place of r.
  - PE(r,c) therefore receives matching k indices at t = k + r + c.
  - Last t moves to SETTLE.
- SETTLE: PE_LAT cycles with all operand valids 0; then DRAIN with element index e := 0.
- DRAIN:
  - res_valid=1; res_row = e / SIZE; res_col = e % SIZE (row-major order).
  - On res_valid & res_ready, e increments.
  - Row, col and last stay stable while res_valid & !res_ready.
  - res_last = (e == SIZE*SIZE-1). The handshake on the last element moves to DONE.
- DONE: done=1 for one cycle, busy=1; next state IDLE. The earliest accepted new start is in the IDLE cycle that follows.
- start outside IDLE is ignored: no error, no effect.
- busy is registered and equals (state != IDLE).
- Total latency with res_ready held high: 1 + (k_reg+2*SIZE-2) + PE_LAT + SIZE*SIZE + 1 cycles from CLEAR entry to the done pulse.

Optional Feature:
- Macro SYSTOLIC_SCHED_PERF_CNT_EN.
- When defined:
  - perf_stall_cycles counts cycles in DRAIN with res_valid & !res_ready.
  - Saturates at 16'hFFFF.
  - Clears on the CLEAR state and on rst.
  - Holds its value after done.
- When undefined: perf_stall_cycles is tied to 0 and no counter logic is synthesised.

Test Plan:
- rst then idle 5 cycles -> all outputs 0, busy=0.
- start, k_len=4, res_ready=1:
  - acc_clear in the first cycle.
  - FEED 10 cycles; a_row_valid = 0001, 0011, 0111, 1111, ..., 1000 over t=0..9.
  - Row 3 k = 0..3 at t = 3..6.
  - 16 results row-major; res_last on (3,3); done exactly 29 cycles after CLEAR entry.
- start with k_len=0, then with k_len=17 -> cmd_err pulses each time; busy stays 0.
- k_len=1, res_ready toggling 1,0,1,0 -> each element held while ready=0; 16 accepted, no skips or repeats; perf_stall_cycles=15 with SYSTOLIC_SCHED_PERF_CNT_EN defined, 0 without.
- start pulsed during FEED and DRAIN -> ignored; tile completes unchanged.
- rst asserted in the middle of DRAIN (e=7) -> IDLE next cycle, res_valid=0, no done; a new start with k_len=2 runs cleanly.
